// File: rtl/difftest_commit_sequencer.sv
// difftest_commit_sequencer
//   Captures up to COMMITS retired instructions plus one trap per cycle into an
//   in-order FIFO and replays them one per cycle to a co-simulation checker.
//   It halts on the first checker mismatch and flags dropped retirement groups.
// Ports:
//   clock, reset                 clock / synchronous active-high reset
//   in_valid/pc/insn/wen/waddr/wdata  per-slot retirement (slot 0 oldest)
//   trap_valid, trap_cause       trap event, younger than same-cycle commits
//   out_valid/ready + out_*      head entry handshake toward the checker
//   res_valid, res_ok            checker verdict strobe
//   fail, overflow               sticky mismatch / drop flags
//   level, retired               occupancy and accepted-commit count
module difftest_commit_sequencer #(
    parameter int COMMITS = 2,
    parameter int DEPTH   = 16,
    parameter int LW      = $clog2(DEPTH) + 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [COMMITS-1:0]      in_valid,
    input  logic [64*COMMITS-1:0]   in_pc,
    input  logic [32*COMMITS-1:0]   in_insn,
    input  logic [COMMITS-1:0]      in_wen,
    input  logic [5*COMMITS-1:0]    in_waddr,
    input  logic [64*COMMITS-1:0]   in_wdata,
    input  logic                    trap_valid,
    input  logic [63:0]             trap_cause,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_kind,
    output logic [63:0]             out_pc,
    output logic [31:0]             out_insn,
    output logic                    out_wen,
    output logic [4:0]              out_waddr,
    output logic [63:0]             out_wdata,
    input  logic                    res_valid,
    input  logic                    res_ok,
    output logic                    fail,
    output logic                    overflow,
    output logic [LW-1:0]           level,
    output logic [63:0]             retired
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic        kind;
        logic [63:0] pc;
        logic [31:0] insn;
        logic        wen;
        logic [4:0]  waddr;
        logic [63:0] wdata;
    } entry_t;

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t          state;
    entry_t          mem [DEPTH];
    logic [PW-1:0]   wptr, rptr;
    entry_t          head;

    // off[i] = number of valid slots below slot i; off[COMMITS] = commit count.
    logic [LW-1:0]   off  [COMMITS+1];
    logic [PW-1:0]   widx [COMMITS+1];
    logic [LW-1:0]   n, free, acc_n;
    logic            accept, drop, xfer;

    always_comb begin
        off[0] = '0;
        for (int i = 0; i < COMMITS; i++)
            off[i+1] = off[i] + {{(LW-1){1'b0}}, in_valid[i]};
        for (int i = 0; i <= COMMITS; i++)
            widx[i] = wptr + off[i][PW-1:0];
    end

    assign n      = off[COMMITS] + {{(LW-1){1'b0}}, trap_valid};
    // Free space is taken from the start-of-cycle level; a concurrent pop does
    // not make room for this cycle's group.
    assign free   = LW'(DEPTH) - level;
    assign accept = (state == RUN) && (n != '0) && (n <= free);
    assign drop   = (state == RUN) && (n > free);
    assign acc_n  = accept ? n : '0;

    assign head      = mem[rptr];
    assign out_valid = (state == RUN) && (level != '0);
    assign xfer      = out_valid && out_ready;
    assign out_kind  = head.kind;
    assign out_pc    = head.pc;
    assign out_insn  = head.insn;
    assign out_wen   = head.wen;
    assign out_waddr = head.waddr;
    assign out_wdata = head.wdata;

    // Storage carries no reset; validity is tracked by the pointers and level.
    always_ff @(posedge clock) begin
        if (!reset && accept) begin
            for (int i = 0; i < COMMITS; i++) begin
                if (in_valid[i])
                    mem[widx[i]] <= '{kind: 1'b0,
                                      pc:    in_pc[64*i +: 64],
                                      insn:  in_insn[32*i +: 32],
                                      wen:   in_wen[i],
                                      waddr: in_waddr[5*i +: 5],
                                      wdata: in_wdata[64*i +: 64]};
            end
            if (trap_valid)
                mem[widx[COMMITS]] <= '{kind: 1'b1, pc: '0, insn: '0, wen: 1'b0,
                                        waddr: '0, wdata: trap_cause};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= RUN;
            fail     <= 1'b0;
            overflow <= 1'b0;
            level    <= '0;
            retired  <= '0;
            wptr     <= '0;
            rptr     <= '0;
        end else begin
            if (state == RUN && res_valid && !res_ok) begin
                state <= HALT;
                fail  <= 1'b1;
            end
            if (drop)
                overflow <= 1'b1;
            if (accept)
                wptr <= wptr + acc_n[PW-1:0];
            if (xfer) begin
                rptr <= rptr + PW'(1);
                if (!head.kind)
                    retired <= retired + 64'd1;
            end
            level <= level + acc_n - {{(LW-1){1'b0}}, xfer};
        end
    end
endmodule

// File: tb/tb_difftest_commit_sequencer.sv
module tb_difftest_commit_sequencer;
    localparam int COMMITS = 2;
    localparam int DEPTH   = 16;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [COMMITS-1:0]    in_valid;
    logic [64*COMMITS-1:0] in_pc;
    logic [32*COMMITS-1:0] in_insn;
    logic [COMMITS-1:0]    in_wen;
    logic [5*COMMITS-1:0]  in_waddr;
    logic [64*COMMITS-1:0] in_wdata;
    logic                  trap_valid;
    logic [63:0]           trap_cause;
    logic                  out_valid, out_ready, out_kind, out_wen;
    logic [63:0]           out_pc, out_wdata;
    logic [31:0]           out_insn;
    logic [4:0]            out_waddr;
    logic                  res_valid, res_ok, fail, overflow;
    logic [LW-1:0]         level;
    logic [63:0]           retired;

    int n_tests = 0;
    int n_fail  = 0;

    difftest_commit_sequencer #(.COMMITS(COMMITS), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_pc(in_pc), .in_insn(in_insn), .in_wen(in_wen),
        .in_waddr(in_waddr), .in_wdata(in_wdata),
        .trap_valid(trap_valid), .trap_cause(trap_cause),
        .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
        .out_pc(out_pc), .out_insn(out_insn), .out_wen(out_wen),
        .out_waddr(out_waddr), .out_wdata(out_wdata),
        .res_valid(res_valid), .res_ok(res_ok),
        .fail(fail), .overflow(overflow), .level(level), .retired(retired)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle so outputs reflect the new state.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        in_valid = '0; in_pc = '0; in_insn = '0; in_wen = '0;
        in_waddr = '0; in_wdata = '0; trap_valid = 1'b0; trap_cause = '0;
    endtask

    task automatic put(input int s, input logic [63:0] pc);
        in_valid[s]          = 1'b1;
        in_pc[64*s +: 64]    = pc;
        in_insn[32*s +: 32]  = 32'h13 + 32'(s);
        in_wen[s]            = 1'b1;
        in_waddr[5*s +: 5]   = 5'(s + 1);
        in_wdata[64*s +: 64] = pc ^ 64'hff;
    endtask

    initial begin
        clr();
        reset = 1'b1; out_ready = 1'b0; res_valid = 1'b0; res_ok = 1'b0;
        step(); step();
        reset = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_fail",      64'(fail),      64'd0);
        chk("rst_overflow",  64'(overflow),  64'd0);
        chk("rst_level",     64'(level),     64'd0);
        chk("rst_retired",   retired,        64'd0);

        // Two commits in one cycle replay oldest first.
        out_ready = 1'b1;
        put(0, 64'h8000_0000); put(1, 64'h8000_0004);
        step(); clr();
        chk("t1_level2",   64'(level),     64'd2);
        chk("t1_head0_pc", out_pc,         64'h8000_0000);
        chk("t1_head0_wd", out_wdata,      64'h8000_00ff);
        chk("t1_head0_wa", 64'(out_waddr), 64'd1);
        chk("t1_head0_k",  64'(out_kind),  64'd0);
        step();
        chk("t1_head1_pc", out_pc,         64'h8000_0004);
        chk("t1_head1_in", 64'(out_insn),  64'h14);
        chk("t1_ret1",     retired,        64'd1);
        step();
        chk("t1_ret2",     retired,        64'd2);
        chk("t1_level0",   64'(level),     64'd0);
        chk("t1_empty",    64'(out_valid), 64'd0);

        // Slot 1 only plus a trap: commit first, then the trap.
        put(1, 64'h100); trap_valid = 1'b1; trap_cause = 64'h8;
        step(); clr();
        chk("t2_level2",  64'(level),    64'd2);
        chk("t2_c_pc",    out_pc,        64'h100);
        chk("t2_c_kind",  64'(out_kind), 64'd0);
        step();
        chk("t2_t_kind",  64'(out_kind), 64'd1);
        chk("t2_t_wdata", out_wdata,     64'h8);
        chk("t2_t_pc",    out_pc,        64'd0);
        chk("t2_t_wen",   64'(out_wen),  64'd0);
        step();
        chk("t2_ret",     retired,       64'd3);
        chk("t2_level0",  64'(level),    64'd0);

        // Fill with 3-entry groups while the checker stalls.
        out_ready = 1'b0;
        for (int g = 0; g < 5; g++) begin
            clr();
            put(0, 64'h1000 + 64'(g) * 64'h10);
            put(1, 64'h1004 + 64'(g) * 64'h10);
            trap_valid = 1'b1; trap_cause = 64'(g);
            step();
        end
        chk("t3_level15", 64'(level),    64'd15);
        chk("t3_no_ovf",  64'(overflow), 64'd0);
        step();  // sixth group: 3 > 1 free, dropped whole
        chk("t3_ovf",     64'(overflow), 64'd1);
        chk("t3_level15b",64'(level),    64'd15);
        clr(); put(0, 64'h3000);
        step();  // exactly one free slot: accepted
        chk("t3_level16", 64'(level),    64'd16);
        out_ready = 1'b1;
        step();  // full: the pop does not make room for this entry
        clr();
        chk("t4_level15", 64'(level),    64'd15);
        chk("t4_head_pc", out_pc,        64'h1004);
        chk("t4_ovf",     64'(overflow), 64'd1);

        // Reset, build level 4, then a mismatch with a concurrent pop.
        out_ready = 1'b0;
        reset = 1'b1; step(); reset = 1'b0;
        chk("t5_rst_ovf", 64'(overflow), 64'd0);
        put(0, 64'h4000); put(1, 64'h4004); step();
        clr(); put(0, 64'h4008); put(1, 64'h400c); step();
        clr();
        chk("t5_level4",  64'(level),     64'd4);
        res_valid = 1'b1; res_ok = 1'b1;
        step();
        chk("t5_ok_fail", 64'(fail),      64'd0);
        chk("t5_ok_vld",  64'(out_valid), 64'd1);
        res_ok = 1'b0; out_ready = 1'b1;
        step();
        res_valid = 1'b0;
        chk("t5_fail",    64'(fail),      64'd1);
        chk("t5_vld0",    64'(out_valid), 64'd0);
        chk("t5_level3",  64'(level),     64'd3);
        chk("t5_ret1",    retired,        64'd1);
        put(0, 64'h5000); put(1, 64'h5004);
        step(); step();
        chk("t5_frz_lvl", 64'(level),     64'd3);
        chk("t5_frz_ret", retired,        64'd1);
        chk("t5_frz_vld", 64'(out_valid), 64'd0);

        // Reset out of HALT; inputs during reset are ignored.
        reset = 1'b1; step(); reset = 1'b0; clr();
        chk("t6_fail",    64'(fail),      64'd0);
        chk("t6_ovf",     64'(overflow),  64'd0);
        chk("t6_level",   64'(level),     64'd0);
        chk("t6_ret",     retired,        64'd0);
        put(0, 64'h2000);
        step(); clr();
        chk("t6_vld",     64'(out_valid), 64'd1);
        chk("t6_pc",      out_pc,         64'h2000);
        step();
        chk("t6_ret1",    retired,        64'd1);
        chk("t6_level0",  64'(level),     64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
